// File: rtl/led_pkg.sv
// Shared types and constants for the LED sweep monitor slice.
// Holds the FSM state enum, the default bus width and the direction encodings.
package led_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    START  = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_sweep_monitor_if.sv
// Bundle between the LED driver side (master) and the sweep monitor (slave).
// Carries the observed LED bus, its strobe and the monitor's status outputs.
interface led_sweep_monitor_if
  import led_pkg::*;
#(
  parameter int W = LED_W
);
  localparam int PW = $clog2(W);

  logic [W-1:0]  LED_in;
  logic          sample_en;
  logic [PW-1:0] position;
  logic          direction;
  logic          locked;
  logic          error;
  logic [7:0]    sweep_count;
  logic [7:0]    error_count;

  modport master (
    output LED_in, sample_en,
    input  position, direction, locked, error, sweep_count, error_count
  );

  modport slave (
    input  LED_in, sample_en,
    output position, direction, locked, error, sweep_count, error_count
  );

endinterface

// File: rtl/led_onehot_decode.sv
// Combinational one-hot decoder: index of the set bit plus a flag that is
// high only when exactly one bit of the bus is set.
module led_onehot_decode
  import led_pkg::*;
#(
  parameter  int W  = LED_W,
  localparam int PW = $clog2(W)
) (
  input  logic [W-1:0]  led,
  output logic [PW-1:0] index,
  output logic          onehot_valid
);

  logic seen;
  logic multi;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    index = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (led[i]) begin
        if (seen) multi = 1'b1;
        seen  = 1'b1;
        index = PW'(i);
      end
    end
    onehot_valid = seen & ~multi;
  end

endmodule

// File: rtl/led_sweep_monitor.sv
// Checks the bouncing single-LED sweep: tracks position/direction, counts
// round trips and faults, and resynchronises by itself after a fault.
module led_sweep_monitor
  import led_pkg::*;
#(
  parameter int W = LED_W
) (
  input logic               Clock,
  input logic               Reset,
  led_sweep_monitor_if.slave bus
);

  localparam int            PW      = $clog2(W);
  localparam logic [PW-1:0] TOP_IDX = PW'(W - 1);

  state_t        state;
  logic [PW-1:0] position_q;
  logic          direction_q;
  logic          error_q;
  logic [7:0]    sweep_q;
  logic [7:0]    errcnt_q;
  logic [PW-1:0] hold_idx;
  logic          hold_valid;

  logic [PW-1:0] dec_idx;
  logic          dec_valid;
  logic [PW-1:0] next_idx;
  logic          match;
  logic          fault;
  logic          step_up;
  logic          step_dn;
  logic          relock;

  led_onehot_decode #(.W(W)) u_decode (
    .led          (bus.LED_in),
    .index        (dec_idx),
    .onehot_valid (dec_valid)
  );

  // Arriving at an end bit forces the direction to bounce back.
  function automatic logic end_dir(input logic [PW-1:0] idx, input logic d);
    if (idx == TOP_IDX)   return DIR_DOWN;
    else if (idx == '0)   return DIR_UP;
    else                  return d;
  endfunction

  // The direction already flips at the ends, so next_idx never wraps in TRACK.
  assign next_idx = (direction_q == DIR_UP) ? position_q + 1'b1 : position_q - 1'b1;
  assign match    = dec_valid && (dec_idx == next_idx);

  // Adjacency is compared one bit wider so the top index cannot alias to 0.
  assign step_up = ({1'b0, dec_idx} == {1'b0, hold_idx} + 1'b1);
  assign step_dn = ({1'b0, hold_idx} == {1'b0, dec_idx} + 1'b1);
  assign relock  = hold_valid && dec_valid && (step_up || step_dn);

  always_comb begin
    fault = 1'b0;
    if (bus.sample_en) begin
      unique case (state)
        START:   fault = (bus.LED_in != '0) && (bus.LED_in != W'(1));
        TRACK:   fault = !match;
        default: fault = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= START;
      position_q  <= '0;
      direction_q <= DIR_UP;
      error_q     <= 1'b0;
      sweep_q     <= '0;
      errcnt_q    <= '0;
      hold_idx    <= '0;
      hold_valid  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      error_q <= 1'b0;
      if (fault) begin
        error_q    <= 1'b1;
        errcnt_q   <= (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
        state      <= RESYNC;
        hold_idx   <= dec_idx;
        hold_valid <= dec_valid;
      end else if (bus.sample_en) begin
        unique case (state)
          START: begin
            if (bus.LED_in == W'(1)) begin
              state       <= TRACK;
              position_q  <= '0;
              direction_q <= DIR_UP;
            end
          end
          TRACK: begin
            position_q  <= dec_idx;
            direction_q <= end_dir(dec_idx, direction_q);
            if (dec_idx == '0) sweep_q <= sweep_q + 8'd1;
          end
          RESYNC: begin
            if (relock) begin
              state       <= TRACK;
              position_q  <= dec_idx;
              direction_q <= end_dir(dec_idx, step_up ? DIR_UP : DIR_DOWN);
            end else begin
              hold_idx   <= dec_idx;
              hold_valid <= dec_valid;
            end
          end
          default: state <= START;
        endcase
      end
    end
  end

  assign bus.position    = position_q;
  assign bus.direction   = direction_q;
  assign bus.locked      = (state == TRACK);
  assign bus.error       = error_q;
  assign bus.sweep_count = sweep_q;
  assign bus.error_count = errcnt_q;

endmodule

// File: doc/led_sweep_monitor.md
# led_sweep_monitor

Checks the bouncing single-LED pattern that the LED light block drives, using the same board clock. It decodes the one-hot LED bus into a position and a direction, confirms that each step matches the expected sweep, and counts completed round trips and sequence errors. After a fault it resynchronises on its own. Its outputs go to the status display and to the self-check logic.

## Interface
- `W`, default 8: LED bus width. Legal range 3..8. The sweep period is 2·(W−1) steps.
- `Clock`  in  1: single clock; all state changes on its rising edge.
- `Reset`  in  1: asynchronous, active-high.
- `LED_in`  in  W: observed LED bus. Legal values are 0 or exactly one bit set.
- `sample_en`  in  1: strobe, high for one cycle for each LED update. `LED_in` is sampled only when `sample_en` is high.
- `position`  out  $clog2(W): index of the lit LED.
- `direction`  out  1: 0 = moving toward the MSB, 1 = moving toward the LSB.
- `locked`  out  1: high while the monitor is in TRACK.
- `error`  out  1: one-cycle pulse on each detected fault.
- `sweep_count`  out  8: completed round trips, wraps modulo 256.
- `error_count`  out  8: detected faults, saturates at 255.

## Operation
- The expected sequence is 1, 2, 4, …, 2^(W−1), 2^(W−2), …, 2, 1, 2, …
- Direction flips on arriving at either end bit.
- FSM states are START, TRACK and RESYNC. The monitor enters START on reset.
- START:
  - `LED_in` = 0: stay in START.
  - `LED_in` = 1: go to TRACK with position 0 and direction 0.
  - Any other value: pulse `error`, increment `error_count`, go to RESYNC holding the decoded index. A non-one-hot value holds no index.
- TRACK: compare `LED_in` with the expected next value.
  - Match: update `position`. Set direction to 1 on reaching bit W−1 and to 0 on reaching bit 0.
  - Match that reaches bit 0 coming from bit 1: increment `sweep_count`.
  - Mismatch, including 0 or a multi-hot value: pulse `error`, increment `error_count`, go to RESYNC.
- RESYNC:
  - A one-hot sample adjacent to the stored index goes to TRACK.
  - The new direction is taken from the step: a step toward a higher index gives 0, a step toward a lower index gives 1.
  - If the new index is an end bit, the direction flips as it does in TRACK.
  - Any other one-hot sample replaces the stored index and the monitor stays in RESYNC.
  - A 0 or multi-hot sample clears the stored index's valid flag and the monitor stays in RESYNC.
  - RESYNC raises no further errors, so one fault counts once.
- `sample_en` low: all state and outputs hold.

## Timing
- Reset values: `position` = 0, `direction` = 0, `locked` = 0, `error` = 0, `sweep_count` = 0, `error_count` = 0, state START.
- All outputs are registered. A sample taken at edge N is reflected at edge N+1 (latency 1 cycle).
- `error` is high for exactly one cycle after the faulting sample.
- `sample_en` may be asserted on back-to-back cycles, and every strobe is evaluated.
- On the cycle a fault is detected, `locked` drops together with the `error` pulse.
- Reset asserted mid-sweep clears everything immediately, with no dependence on `Clock`. The first sample after release is handled by START.
- `error_count` at 255 stays at 255 while `error` still pulses.
- `sweep_count` wraps from 255 to 0.

## Structure
- Package `led_pkg` holds:
  - the `state_t` enum (START, TRACK, RESYNC);
  - the `LED_W` default constant (8);
  - the direction encodings `DIR_UP` = 0 and `DIR_DOWN` = 1.
- Sub-module `led_onehot_decode` is combinational: W-bit input, index output and `onehot_valid` flag.
  - `onehot_valid` is high only when exactly one bit is set.
- The top level contains the FSM, the expected-next calculation (a shift of the current position in the current direction) and both counters.

## Test plan
- Reset, then feed 0, 1, 2, 4 … 128, 64 … 1 with one strobe every 4 cycles:
  - `locked` = 1 from the second sample;
  - `sweep_count` = 1 after the final 1;
  - `error` never asserts;
  - `position`/`direction` track the sweep, with `direction` = 1 from 128 onward.
- In TRACK at 16 going up, inject 8'h40:
  - `error` pulses once, `error_count` = 1, `locked` = 0;
  - then 8'h20 re-locks with position 5 and direction 1.
- Inject 8'h03 in TRACK:
  - `error` pulses, state goes to RESYNC;
  - then 8'h04, 8'h08 gives lock with position 3 and direction 0.
- Force 300 faults:
  - `error_count` saturates at 255 while `error` still pulses;
  - run 257 full sweeps and check `sweep_count` wraps to 1.
- Assert `Reset` asynchronously between edges mid-sweep:
  - all outputs go to 0 immediately;
  - a sample of 0 then 1 after release re-locks with position 0.
- Hold `sample_en` low for 100 cycles while `LED_in` changes randomly: no output changes.
